// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states
// and the fixed quotient returned on divide-by-zero.
package hilo_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Wide enough for any WIDTH up to 64; the top slices what it needs.
  localparam logic [63:0] DIV0_QUOT = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation, used both to take operand magnitudes
// and to restore the sign of products, quotients and remainders.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_i,
  input  logic         neg_i,
  output logic [W-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + W'(1)) : in_i;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU engine producing HI/LO write data and
// a one-cycle write strobe after a fixed WIDTH+1 cycle latency.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] HI_input,
  output logic [WIDTH-1:0] LO_input,
  output logic             regWrite
);

  localparam logic [WIDTH-1:0] QUOT_DIV0 = DIV0_QUOT[WIDTH-1:0];
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic             neg_res_q;
  logic             neg_rem_q;
  logic             div0_q;
  logic [WIDTH-1:0] a_raw_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             wr_q;

  logic             start_signed;
  logic             start_div;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign start_signed = op_is_signed(op);
  assign start_div    = op_is_div(op);

  muldiv_sign_fix #(.W(WIDTH)) u_fix_a (
    .in_i (a),
    .neg_i(start_signed & a[WIDTH-1]),
    .out_o(mag_a)
  );

  muldiv_sign_fix #(.W(WIDTH)) u_fix_b (
    .in_i (b),
    .neg_i(start_signed & b[WIDTH-1]),
    .out_o(mag_b)
  );

  // Shift-add step: acc_lo holds the multiplier, consumed LSB first.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_d;
  logic [WIDTH-1:0] mul_lo_d;

  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi_d = mul_sum[WIDTH:1];
  assign mul_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

  // Restoring step: acc_lo holds the dividend and fills with quotient bits.
  // After a successful subtract the difference is below the divisor, so bit
  // WIDTH is always clear then; testing it alongside the borrow is harmless.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_d;
  logic [WIDTH-1:0] div_lo_d;

  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
  assign div_ge    = ~|div_diff[WIDTH+1:WIDTH];
  assign div_hi_d  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_lo_d  = {acc_lo_q[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .in_i ({mul_hi_d, mul_lo_d}),
    .neg_i(neg_res_q),
    .out_o(prod_fix)
  );

  muldiv_sign_fix #(.W(WIDTH)) u_fix_quot (
    .in_i (div_lo_d),
    .neg_i(neg_res_q),
    .out_o(quot_fix)
  );

  muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (
    .in_i (div_hi_d),
    .neg_i(neg_rem_q),
    .out_o(rem_fix)
  );

  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  always_comb begin
    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      res_hi = div0_q ? a_raw_q   : rem_fix;
      res_lo = div0_q ? QUOT_DIV0 : quot_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      a_raw_q   <= '0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      wr_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wr_q <= 1'b0;
          if (start) begin
            is_div_q  <= start_div;
            neg_res_q <= start_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q <= start_signed & a[WIDTH-1];
            div0_q    <= (b == '0);
            a_raw_q   <= a;
            opnd_q    <= start_div ? mag_b : mag_a;
            acc_hi_q  <= '0;
            acc_lo_q  <= start_div ? mag_a : mag_b;
            cnt_q     <= '0;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          acc_hi_q <= is_div_q ? div_hi_d : mul_hi_d;
          acc_lo_q <= is_div_q ? div_lo_d : mul_lo_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            wr_q    <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          wr_q    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          wr_q    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign regWrite = wr_q;
  assign HI_input = hi_q;
  assign LO_input = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: a vector table of ops with
// hand-computed HI/LO, plus start-while-busy and mid-operation reset sequences.
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  localparam int LAT = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] HI_input;
  logic [31:0] LO_input;
  logic        regWrite;

  int total = 0;
  int bad   = 0;

  hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .HI_input(HI_input),
    .LO_input(LO_input),
    .regWrite(regWrite)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
  endtask

  // Follows one accepted operation from the cycle after start; operands are
  // scrambled so that only the start-cycle values can affect the result.
  task automatic watch(input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
    int          wr_cyc = -1;
    int          wr_cnt = 0;
    bit          busy_ok = 1'b1;
    logic [31:0] cap_hi = '0;
    logic [31:0] cap_lo = '0;
    for (int k = 1; k <= LAT + 3; k++) begin
      tick();
      start = 1'b0;
      op    = 2'($urandom);
      a     = $urandom;
      b     = $urandom;
      if (busy !== (k <= LAT)) busy_ok = 1'b0;
      if (regWrite === 1'b1) begin
        wr_cnt++;
        if (wr_cyc < 0) begin
          wr_cyc = k;
          cap_hi = HI_input;
          cap_lo = LO_input;
        end
      end
    end
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
    check({tag, "_wrcyc"}, 64'(wr_cyc), 64'(LAT));
    check({tag, "_wrcnt"}, 64'(wr_cnt), 64'd1);
    check({tag, "_hi"}, 64'(cap_hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(cap_lo), 64'(exp_lo));
    check({tag, "_hold"}, {HI_input, LO_input}, {exp_hi, exp_lo});
  endtask

  initial begin
    int wr_cyc;
    int wr_cnt;
    int busy_cnt;
    logic [31:0] cap_hi;
    logic [31:0] cap_lo;

    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{OP_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    vecs[6]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[10] = '{OP_MULT,  32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};
    vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vecs[12] = '{OP_DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E};
    vecs[13] = '{OP_MULT,  32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};

    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr", 64'(regWrite), 64'd0);
    check("rst_hilo", {HI_input, LO_input}, 64'd0);

    for (int i = 0; i < 14; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      watch(vecs[i].hi, vecs[i].lo, $sformatf("v%0d", i));
    end

    // start pulses at cycles 5 and 33 must be dropped; cycle 34 is accepted.
    launch(OP_MULTU, 32'h10, 32'h20);
    wr_cyc = -1;
    wr_cnt = 0;
    cap_hi = '0;
    cap_lo = '0;
    for (int k = 1; k <= 34; k++) begin
      tick();
      start = 1'b0;
      if (regWrite === 1'b1) begin
        wr_cnt++;
        if (wr_cyc < 0) begin
          wr_cyc = k;
          cap_hi = HI_input;
          cap_lo = LO_input;
        end
      end
      if (k == 5 || k == 33) launch(OP_DIVU, 32'd1000, 32'd3);
      if (k == 34) begin
        check("ign_busy34", 64'(busy), 64'd0);
        launch(OP_MULT, 32'hFFFFFFFE, 32'd3);
      end
    end
    check("ign_wrcyc", 64'(wr_cyc), 64'(LAT));
    check("ign_wrcnt", 64'(wr_cnt), 64'd1);
    check("ign_hilo", {cap_hi, cap_lo}, 64'h00000000_00000200);
    watch(32'hFFFFFFFF, 32'hFFFFFFFA, "after_ign");

    // Reset during cycle 10 of an operation aborts it with no write.
    launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int k = 1; k <= 10; k++) begin
      tick();
      start = 1'b0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_wr", 64'(regWrite), 64'd0);
    check("abort_hilo", {HI_input, LO_input}, 64'd0);
    wr_cnt   = 0;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (regWrite !== 1'b0) wr_cnt++;
      if (busy !== 1'b0) busy_cnt++;
    end
    check("abort_nowr", 64'(wr_cnt), 64'd0);
    check("abort_idle", 64'(busy_cnt), 64'd0);
    check("abort_hold", {HI_input, LO_input}, 64'd0);

    launch(OP_DIVU, 32'd100, 32'd7);
    watch(32'd2, 32'd14, "recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
